// File: rtl/ps2_kbd_event_rx.sv
// PS/2 keyboard receiver: parity/framing/timeout checks, E0/F0 decode, repeat filter, event FIFO.
// Latency: an event is written at the edge ending the stop-bit sample cycle; head/ready/count show it one cycle later.
// Backpressure: none toward the keyboard; a full FIFO drops the event and raises overflow until the next pop.
module ps2_kbd_event_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int FILTER_REPEAT  = 1
) (
  input  logic                          clk,
  input  logic                          clrn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          nextdata_n,
  output logic [7:0]                    data,
  output logic                          is_break,
  output logic                          is_ext,
  output logic                          ready,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   prev_clk_q;
  logic                   ps2_clk_s, ps2_dat_s, fall;
  state_t                 state_q, state_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   frame_ok, frame_bad, timeout;
  logic                   ext_q, ext_d, brk_q, brk_d;
  logic [9:0]             held_q, held_d;
  logic                   push_vld;
  logic [9:0]             push_dat;
  logic [9:0]             mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          cnt_q;
  logic                   nd_q, ovf_q, frame_err_q;
  logic                   pop, full, wr_en, drop;
  logic [9:0]             head;

  assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
  assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
  assign fall      = prev_clk_q & ~ps2_clk_s;

  // Synchronise the PS/2 pins; idle-high reset so no false edge appears after reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      prev_clk_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      prev_clk_q <= ps2_clk_s;
    end
  end

  // Frame FSM and timeout counter state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Frame next-state: sample data on each synced falling edge, abort on a stalled clock.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    timeout   = (state_q != IDLE) && !fall && (to_cnt_q == TW'(TIMEOUT_CYCLES));
    if (fall || state_q == IDLE) to_cnt_d = '0;
    else                         to_cnt_d = to_cnt_q + TW'(1);
    case (state_q)
      IDLE: if (fall && !ps2_dat_s) begin
        state_d   = DATA;
        bit_idx_d = 3'd0;
      end
      DATA: if (fall) begin
        shift_d   = {ps2_dat_s, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        parity_d = ps2_dat_s;
        state_d  = STOP;
      end
      STOP: if (fall) begin
        if (ps2_dat_s && (^shift_q ^ parity_q)) frame_ok  = 1'b1;
        else                                    frame_bad = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d   = IDLE;
      frame_bad = 1'b1;
      to_cnt_d  = '0;
    end
  end

  // Prefix decode and typematic repeat filter for a completed byte.
  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    held_d   = held_q;
    push_vld = 1'b0;
    push_dat = {ext_q, brk_q, shift_q};
    if (frame_bad) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (frame_ok) begin
      if (shift_q == 8'hE0) ext_d = 1'b1;
      else if (shift_q == 8'hF0) brk_d = 1'b1;
      else begin
        ext_d    = 1'b0;
        brk_d    = 1'b0;
        push_vld = 1'b1;
        if (FILTER_REPEAT != 0) begin
          if (!brk_q) begin
            if (held_q == {1'b1, ext_q, shift_q}) push_vld = 1'b0;
            else                                  held_d   = {1'b1, ext_q, shift_q};
          end else if (held_q == {1'b1, ext_q, shift_q}) begin
            held_d = '0;
          end
        end
      end
    end
  end

  // Prefix flags and held-key register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ext_q  <= 1'b0;
      brk_q  <= 1'b0;
      held_q <= '0;
    end else begin
      ext_q  <= ext_d;
      brk_q  <= brk_d;
      held_q <= held_d;
    end
  end

  assign pop   = nd_q & ~nextdata_n & (cnt_q != '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_en = push_vld & (~full | pop);
  assign drop  = push_vld & full & ~pop;

  // Event storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat;
  end

  // FIFO pointers, occupancy, overflow flag, pop edge detect and error pulse.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      nd_q        <= 1'b1;
      ovf_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      nd_q        <= nextdata_n;
      frame_err_q <= frame_bad;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !wr_en) cnt_q <= cnt_q - CW'(1);
      if (pop)       ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign ready     = (cnt_q != '0);
  assign data      = ready ? head[7:0] : 8'h00;
  assign is_break  = ready & head[8];
  assign is_ext    = ready & head[9];
  assign overflow  = ovf_q;
  assign frame_err = frame_err_q;
  assign count     = cnt_q;
endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// Directed bench for ps2_kbd_event_rx with an event scoreboard.
// Latency: checks head visibility one cycle after the stop-bit sample.
// Backpressure: exercises full-FIFO drop, overflow and simultaneous push/pop.
module tb_ps2_kbd_event_rx;
  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic       nd_nf = 1'b1;
  logic [7:0] data;
  logic       is_break, is_ext, ready, overflow, frame_err;
  logic [2:0] count;
  logic [7:0] nf_data;
  logic       nf_is_break, nf_is_ext, nf_ready, nf_overflow, nf_frame_err;
  logic [3:0] nf_count;

  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  int         fe0;
  logic       nd_prev = 1'b1;
  logic [9:0] exp_q [$];
  logic [9:0] e;

  always #5 clk = ~clk;

  ps2_kbd_event_rx #(.FIFO_DEPTH(4), .SYNC_STAGES(3), .TIMEOUT_CYCLES(2000), .FILTER_REPEAT(1)) u_dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nextdata_n),
    .data(data), .is_break(is_break), .is_ext(is_ext), .ready(ready), .overflow(overflow),
    .frame_err(frame_err), .count(count));

  ps2_kbd_event_rx #(.FIFO_DEPTH(8), .SYNC_STAGES(3), .TIMEOUT_CYCLES(2000), .FILTER_REPEAT(0)) u_nf (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .nextdata_n(nd_nf),
    .data(nf_data), .is_break(nf_is_break), .is_ext(nf_is_ext), .ready(nf_ready), .overflow(nf_overflow),
    .frame_err(nf_frame_err), .count(nf_count));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (clrn && ready && nd_prev && !nextdata_n) begin
      if (exp_q.size() == 0) chk("pop_unexpected", {is_ext, is_break, data}, 0);
      else begin
        e = exp_q.pop_front();
        chk("pop_event", {is_ext, is_break, data}, e);
      end
    end
    nd_prev = nextdata_n;
    if (frame_err) fe_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    #1 clrn = 1'b0;
    ps2_clk = 1'b1; ps2_data = 1'b1; nextdata_n = 1'b1;
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1 clrn = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // mode 0: plain bit; 1: pop request lands in the falling-edge sample cycle; 2: latency check.
  task automatic ps2_bit(input logic v, input int mode);
    ps2_data = v;
    repeat (8) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    if (mode == 1) #1 nextdata_n = 1'b0;
    if (mode == 2) begin
      @(negedge clk); chk("lat_T_ready", ready, 0);
      @(negedge clk); chk("lat_T1_ready", ready, 1); chk("lat_T1_count", count, 1);
    end
    repeat (5) @(posedge clk);
    #1 ps2_clk = 1'b1;
    if (mode == 1) begin
      repeat (2) @(posedge clk);
      #1 nextdata_n = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par, input int mode);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit(~^b ^ bad_par, 0);
    ps2_bit(1'b1, mode);
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic partial(input int nbits);
    ps2_bit(1'b0, 0);
    for (int i = 1; i < nbits; i++) ps2_bit(i[0], 0);
    ps2_data = 1'b1;
  endtask

  task automatic pop_one;
    @(posedge clk);
    #1 nextdata_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 nextdata_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic sb_empty(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    // 1: reset state, single make, latency, pop, pop-while-empty
    do_reset;
    @(negedge clk);
    chk("reset_outputs", {data, is_break, is_ext, ready, overflow, frame_err, count}, 0);
    exp_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 0, 2);
    chk("t1_data", data, 8'h1C);
    chk("t1_flags", {is_ext, is_break}, 0);
    pop_one;
    @(negedge clk);
    chk("t1_after_pop", {ready, count, data}, 0);
    pop_one;
    chk("t1_pop_empty_count", count, 0);
    sb_empty("t1_sb");

    // 2: break and extended prefixes
    do_reset;
    exp_q.push_back({2'b01, 8'h1C});
    send(8'hF0, 0, 0); send(8'h1C, 0, 0);
    chk("t2_count_brk", count, 1);
    exp_q.push_back({2'b10, 8'h75});
    send(8'hE0, 0, 0); send(8'h75, 0, 0);
    exp_q.push_back({2'b11, 8'h75});
    send(8'hE0, 0, 0); send(8'hF0, 0, 0); send(8'h75, 0, 0);
    chk("t2_count", count, 3);
    repeat (3) pop_one;
    sb_empty("t2_sb");

    // 3: typematic repeat filter on vs off
    do_reset;
    exp_q.push_back({2'b00, 8'h1B});
    exp_q.push_back({2'b01, 8'h1B});
    send(8'h1B, 0, 0); send(8'h1B, 0, 0); send(8'h1B, 0, 0);
    send(8'hF0, 0, 0); send(8'h1B, 0, 0);
    chk("t3_filter_count", count, 2);
    chk("t3_nofilter_count", nf_count, 4);
    repeat (2) pop_one;
    sb_empty("t3_sb");

    // 4: parity error, mid-frame timeout, recovery
    do_reset;
    fe0 = fe_cnt;
    send(8'h1C, 1, 0);
    chk("t4_parity_err_pulse", fe_cnt - fe0, 1);
    chk("t4_parity_count", count, 0);
    fe0 = fe_cnt;
    partial(5);
    repeat (2100) @(posedge clk);
    chk("t4_timeout_pulse", fe_cnt - fe0, 1);
    exp_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 0, 0);
    chk("t4_recover_count", count, 1);
    pop_one;
    sb_empty("t4_sb");

    // 5: overflow with depth 4
    do_reset;
    exp_q.push_back({2'b00, 8'h15}); exp_q.push_back({2'b00, 8'h1D});
    exp_q.push_back({2'b00, 8'h24}); exp_q.push_back({2'b00, 8'h2D});
    send(8'h15, 0, 0); send(8'h1D, 0, 0); send(8'h24, 0, 0); send(8'h2D, 0, 0);
    chk("t5_ovf_before", overflow, 0);
    send(8'h2C, 0, 0);
    chk("t5_count_full", count, 4);
    chk("t5_overflow", overflow, 1);
    pop_one;
    chk("t5_ovf_cleared", overflow, 0);
    repeat (3) pop_one;
    sb_empty("t5_sb");

    // 6: simultaneous push and pop while full, then reset mid-frame
    do_reset;
    exp_q.push_back({2'b00, 8'h15}); exp_q.push_back({2'b00, 8'h1D});
    exp_q.push_back({2'b00, 8'h24}); exp_q.push_back({2'b00, 8'h2D});
    send(8'h15, 0, 0); send(8'h1D, 0, 0); send(8'h24, 0, 0); send(8'h2D, 0, 0);
    exp_q.push_back({2'b00, 8'h3C});
    send(8'h3C, 0, 1);
    chk("t6_count_pushpop", count, 4);
    chk("t6_ovf_pushpop", overflow, 0);
    repeat (3) pop_one;
    chk("t6_last_head", data, 8'h3C);
    partial(4);
    #1 clrn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_reset_outputs", {data, is_break, is_ext, ready, overflow, frame_err, count}, 0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    #1 clrn = 1'b1;
    repeat (4) @(posedge clk);
    fe0 = fe_cnt;
    exp_q.push_back({2'b00, 8'h2C});
    send(8'h2C, 0, 0);
    chk("t6_after_reset_count", count, 1);
    chk("t6_after_reset_noerr", fe_cnt - fe0, 0);
    pop_one;
    sb_empty("t6_sb");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
